// File: rtl/mips_ctrl_fsm.sv
// rtl/mips_ctrl_fsm.sv - multi-cycle MIPS control FSM driving fetch, register file, ALU and data memory
module mips_ctrl_fsm #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [4:0]  rf_ra1,
  output logic [4:0]  rf_ra2,
  input  logic [31:0] rf_rd1,
  input  logic [31:0] rf_rd2,
  output logic        rf_we,
  output logic [4:0]  rf_wa,
  output logic [31:0] rf_wd,
  output logic [5:0]  alu_op,
  output logic [5:0]  funct,
  output logic [31:0] alu_in1,
  output logic [31:0] alu_in2,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        halted
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // ALU opcodes driven to the ALU (never the raw instruction opcode for lw/sw/beq)
  localparam logic [5:0] ALU_RTYPE = 6'b000000;
  localparam logic [5:0] ALU_ADD   = 6'b100000;
  localparam logic [5:0] ALU_SUB   = 6'b100011;
  localparam logic [5:0] ALU_AND   = 6'b101011;
  localparam logic [5:0] ALU_OR    = 6'b001101;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  // What the instruction does after EXEC
  typedef enum logic [1:0] {
    K_ALU, K_LW, K_SW, K_BEQ
  } kind_t;

  state_t      state;
  kind_t       kind;
  logic [31:0] pc;
  logic [31:0] ir;
  logic [4:0]  wa;
  logic [31:0] rd2_q;

  logic [5:0]  opc;
  logic [5:0]  fn;
  logic [31:0] imm_s;
  logic [31:0] imm_z;

  kind_t       dec_kind;
  logic [5:0]  dec_op;
  logic [5:0]  dec_fn;
  logic [31:0] dec_in2;
  logic [4:0]  dec_wa;
  logic        dec_legal;
  logic        dec_jump;

  assign opc       = ir[31:26];
  assign fn        = ir[5:0];
  assign imm_s     = {{16{ir[15]}}, ir[15:0]};
  assign imm_z     = {16'h0000, ir[15:0]};
  assign imem_addr = pc;
  assign rf_ra1    = ir[25:21];
  assign rf_ra2    = ir[20:16];

  // Decode the held instruction into ALU controls, operand 2 and destination
  always_comb begin
    dec_kind  = K_ALU;
    dec_op    = ALU_RTYPE;
    dec_fn    = 6'b000000;
    dec_in2   = rf_rd2;
    dec_wa    = ir[20:16];
    dec_legal = 1'b1;
    dec_jump  = 1'b0;
    case (opc)
      OP_RTYPE: begin
        dec_fn    = fn;
        dec_wa    = ir[15:11];
        dec_legal = fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101};
      end
      OP_ADDI: begin
        dec_op  = ALU_ADD;
        dec_in2 = imm_s;
      end
      OP_ANDI: begin
        dec_op  = ALU_AND;
        dec_in2 = imm_z;
      end
      OP_ORI: begin
        dec_op  = ALU_OR;
        dec_in2 = imm_z;
      end
      OP_LW: begin
        dec_kind = K_LW;
        dec_op   = ALU_ADD;
        dec_in2  = imm_s;
      end
      OP_SW: begin
        dec_kind = K_SW;
        dec_op   = ALU_ADD;
        dec_in2  = imm_s;
      end
      OP_BEQ: begin
        dec_kind = K_BEQ;
        dec_op   = ALU_SUB;
      end
      OP_J:    dec_jump  = 1'b1;
      default: dec_legal = 1'b0;
    endcase
  end

  // Control sequencer: state, PC, IR and every registered output
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_FETCH;
      kind       <= K_ALU;
      pc         <= RESET_PC;
      ir         <= 32'h0;
      wa         <= 5'd0;
      rd2_q      <= 32'h0;
      imem_req   <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= 32'h0;
      dmem_wdata <= 32'h0;
      rf_we      <= 1'b0;
      rf_wa      <= 5'd0;
      rf_wd      <= 32'h0;
      alu_op     <= 6'd0;
      funct      <= 6'd0;
      alu_in1    <= 32'h0;
      alu_in2    <= 32'h0;
      halted     <= 1'b0;
    end else begin
      rf_we <= 1'b0;
      case (state)
        S_FETCH: begin
          if (imem_req && imem_ack) begin
            ir       <= imem_rdata;
            pc       <= pc + 32'd4;
            imem_req <= 1'b0;
            state    <= S_DECODE;
          end else begin
            imem_req <= 1'b1;
          end
        end
        S_DECODE: begin
          rd2_q <= rf_rd2;
          wa    <= dec_wa;
          kind  <= dec_kind;
          if (!dec_legal) begin
            if (HALT_ON_ILLEGAL) begin
              halted <= 1'b1;
              state  <= S_HALT;
            end else begin
              imem_req <= 1'b1;
              state    <= S_FETCH;
            end
          end else if (dec_jump) begin
            // pc already holds PC+4, so its top nibble is the jump region
            pc       <= {pc[31:28], ir[25:0], 2'b00};
            imem_req <= 1'b1;
            state    <= S_FETCH;
          end else begin
            alu_op  <= dec_op;
            funct   <= dec_fn;
            alu_in1 <= rf_rd1;
            alu_in2 <= dec_in2;
            state   <= S_EXEC;
          end
        end
        S_EXEC: begin
          case (kind)
            K_LW, K_SW: begin
              dmem_req   <= 1'b1;
              dmem_we    <= (kind == K_SW);
              dmem_addr  <= alu_result;
              dmem_wdata <= rd2_q;
              state      <= S_MEM;
            end
            K_BEQ: begin
              if (alu_zero) begin
                pc <= pc + {imm_s[29:0], 2'b00};
              end
              imem_req <= 1'b1;
              state    <= S_FETCH;
            end
            default: begin
              rf_we <= (wa != 5'd0);
              rf_wa <= wa;
              rf_wd <= alu_result;
              state <= S_WB;
            end
          endcase
        end
        S_MEM: begin
          if (dmem_ack) begin
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            if (kind == K_SW) begin
              imem_req <= 1'b1;
              state    <= S_FETCH;
            end else begin
              rf_we <= (wa != 5'd0);
              rf_wa <= wa;
              rf_wd <= dmem_rdata;
              state <= S_WB;
            end
          end
        end
        S_WB: begin
          imem_req <= 1'b1;
          state    <= S_FETCH;
        end
        default: begin
          imem_req <= 1'b0;
          dmem_req <= 1'b0;
          dmem_we  <= 1'b0;
          halted   <= 1'b1;
        end
      endcase
    end
  end

endmodule
